// File: rtl/systolic_mm_engine.sv
// NxN output-stationary systolic matrix-multiply tile (C = A*B, signed, streaming K).
// Define SA_SATURATE_EN for saturating accumulators and the sat_flag output; default wraps.
module systolic_mm_engine #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_a,
  input  logic [N*DATA_W-1:0] in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*ACC_W-1:0]  out_row,
  output logic                out_last,
`ifdef SA_SATURATE_EN
  output logic                sat_flag,
`endif
  output logic                busy
);

  localparam int unsigned RowW = $clog2(N);
  localparam int unsigned CntW = $clog2(2 * N + 1);
  localparam logic [RowW-1:0] LastRow   = RowW'(N - 1);
  localparam logic [CntW-1:0] FlushLoad = CntW'(2 * N);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFeed  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] flush_q, flush_d;
  logic [RowW-1:0] row_q, row_d;
  logic            accept, drain_done, clr;

  logic [N*DATA_W-1:0]       a_inj, b_inj, a_edge, b_edge;
  logic [N*(N-1)*DATA_W-1:0] a_pipe, b_pipe;
  logic [N*N*ACC_W-1:0]      acc_flat;

  assign in_ready   = (state_q == StIdle) || (state_q == StFeed);
  assign accept     = in_valid && in_ready;
  assign drain_done = (state_q == StDrain) && out_ready && (row_q == LastRow);
  assign clr        = abort || drain_done;

  // Idle cycles push zeros through the array so bubbles never touch C.
  assign a_inj = accept ? in_a : '0;
  assign b_inj = accept ? in_b : '0;

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    row_d   = row_q;
    case (state_q)
      StIdle, StFeed: begin
        if (accept) begin
          state_d = in_last ? StFlush : StFeed;
          if (in_last) flush_d = FlushLoad;
        end
      end
      StFlush: begin
        // Hold until the last beat's product has landed in PE(N-1,N-1).
        if (flush_q == '0) state_d = StDrain;
        else flush_d = flush_q - CntW'(1);
      end
      StDrain: begin
        if (out_ready) begin
          if (row_q == LastRow) begin
            state_d = StIdle;
            row_d   = '0;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      flush_d = '0;
      row_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      row_q   <= row_d;
    end
  end

  // Input skew: lane i of A and B delayed by i cycles.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_lane0
      assign a_edge[DATA_W-1:0] = a_inj[DATA_W-1:0];
      assign b_edge[DATA_W-1:0] = b_inj[DATA_W-1:0];
    end else begin : g_lane
      logic [DATA_W-1:0] a_sr [i];
      logic [DATA_W-1:0] b_sr [i];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else if (clr) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= a_inj[i*DATA_W +: DATA_W];
          b_sr[0] <= b_inj[i*DATA_W +: DATA_W];
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end
      assign a_edge[i*DATA_W +: DATA_W] = a_sr[i-1];
      assign b_edge[i*DATA_W +: DATA_W] = b_sr[i-1];
    end
  end

`ifdef SA_SATURATE_EN
  logic [N*N-1:0] sat_vec;
`endif

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic signed [DATA_W-1:0]   a_nxt, b_nxt, a_q, b_q;
      logic signed [2*DATA_W-1:0] prod_q;
      logic signed [ACC_W-1:0]    acc_q, acc_d;

      if (j == 0) begin : g_a_edge
        assign a_nxt = a_edge[i*DATA_W +: DATA_W];
      end else begin : g_a_hop
        assign a_nxt = a_pipe[(i*(N-1)+j-1)*DATA_W +: DATA_W];
      end
      if (j < N - 1) begin : g_a_out
        assign a_pipe[(i*(N-1)+j)*DATA_W +: DATA_W] = a_q;
      end

      if (i == 0) begin : g_b_edge
        assign b_nxt = b_edge[j*DATA_W +: DATA_W];
      end else begin : g_b_hop
        assign b_nxt = b_pipe[((i-1)*N+j)*DATA_W +: DATA_W];
      end
      if (i < N - 1) begin : g_b_out
        assign b_pipe[(i*N+j)*DATA_W +: DATA_W] = b_q;
      end

`ifdef SA_SATURATE_EN
      logic signed [ACC_W:0] sum;
      logic                  ovf, sat_q;
      assign sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_q);
      assign ovf   = sum[ACC_W] ^ sum[ACC_W-1];
      assign acc_d = !ovf ? sum[ACC_W-1:0] :
                     sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    sat_q <= 1'b0;
        else if (clr) sat_q <= 1'b0;
        else          sat_q <= sat_q | ovf;
      end
      assign sat_vec[i*N+j] = sat_q;
`else
      assign acc_d = acc_q + ACC_W'(prod_q);
`endif

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q    <= '0;
          b_q    <= '0;
          prod_q <= '0;
          acc_q  <= '0;
        end else if (clr) begin
          a_q    <= '0;
          b_q    <= '0;
          prod_q <= '0;
          acc_q  <= '0;
        end else begin
          a_q    <= a_nxt;
          b_q    <= b_nxt;
          prod_q <= (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);
          acc_q  <= acc_d;
        end
      end

      assign acc_flat[(i*N+j)*ACC_W +: ACC_W] = acc_q;
    end
  end

  assign out_valid = (state_q == StDrain);
  assign out_last  = out_valid && (row_q == LastRow);
  assign busy      = (state_q != StIdle);

`ifdef SA_SATURATE_EN
  assign sat_flag = out_valid && (|sat_vec);
`endif

  always_comb begin
    out_row = '0;
    if (state_q == StDrain) begin
      for (int c = 0; c < N; c++) begin
        out_row[c*ACC_W +: ACC_W] = acc_flat[(int'(row_q)*N+c)*ACC_W +: ACC_W];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine (N=4, DATA_W=8, ACC_W=16): directed table,
// abort/reset sequences and randomized jobs checked against a plain matrix-product model.
module tb_systolic_mm_engine;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            abort = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            out_ready = 1'b1;
  logic [N*DW-1:0] in_a = '0;
  logic [N*DW-1:0] in_b = '0;
  logic            in_ready, out_valid, out_last, busy;
  logic [N*AW-1:0] out_row;
`ifdef SA_SATURATE_EN
  logic            sat_flag;
`endif

  always #5 clk = ~clk;

  systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
`ifdef SA_SATURATE_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy)
  );

  typedef struct {
    string             name;
    int                k;
    int                bubbles;
    int                stall;
    bit                junk;
    logic [7:0][31:0]  a_beats;
    logic [7:0][31:0]  b_beats;
    logic [3:0][63:0]  exp_rows;
    bit                exp_sat;
  } vec_t;

  vec_t vecs[5];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // C[i][j] = sum_k A[i][k]*B[k][j]; wraps to 16 bits, or clamps per step when saturating.
  function automatic void model(input logic [7:0][31:0] ab, input logic [7:0][31:0] bb,
                                input int k, output logic [3:0][63:0] rows, output bit sat);
    sat  = 1'b0;
    rows = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int acc;
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          int av, bv;
          av = $signed(ab[kk][i*8 +: 8]);
          bv = $signed(bb[kk][j*8 +: 8]);
          acc += av * bv;
`ifdef SA_SATURATE_EN
          if (acc > 32767) begin acc = 32767; sat = 1'b1; end
          if (acc < -32768) begin acc = -32768; sat = 1'b1; end
`endif
        end
        rows[i][j*16 +: 16] = acc[15:0];
      end
    end
  endfunction

  task automatic feed(input string name, input logic [7:0][31:0] ab, input logic [7:0][31:0] bb,
                      input int k, input int bubbles);
    int guard;
    for (int kk = 0; kk < k; kk++) begin
      in_valid = 1'b1;
      in_a     = ab[kk];
      in_b     = bb[kk];
      in_last  = (kk == k - 1);
      guard    = 0;
      while (!in_ready && guard < 20) begin
        step();
        guard++;
      end
      if (!in_ready) check({name, " in_ready timeout"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_last  = 1'b0;
      if (kk < k - 1) repeat (bubbles) step();
    end
  endtask

  task automatic run_job(input string name, input logic [7:0][31:0] ab,
                         input logic [7:0][31:0] bb, input int k, input int bubbles,
                         input int stall, input bit junk, input logic [3:0][63:0] exp_rows,
                         input bit exp_sat);
    int lat;
    feed(name, ab, bb, k, bubbles);
    if (junk) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_a     = 32'h7f7f7f7f;
      in_b     = 32'h81818181;
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(2 * N + 1));
`ifdef SA_SATURATE_EN
    check({name, " sat_flag"}, 64'(sat_flag), 64'(exp_sat));
`else
    if (exp_sat) check({name, " expects saturation in wrap build"}, 64'd1, 64'd0);
`endif
    for (int r = 0; r < N; r++) begin
      check($sformatf("%s row%0d", name, r), out_row, exp_rows[r]);
      check($sformatf("%s out_last%0d", name, r), 64'(out_last), 64'(r == N - 1));
      if (stall > 0) begin
        out_ready = 1'b0;
        repeat (stall) step();
        check($sformatf("%s row%0d held", name, r), {out_valid, out_row[62:0]},
              {1'b1, exp_rows[r][62:0]});
        out_ready = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    check({name, " idle after drain"}, {62'd0, out_valid, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][31:0] id_beats, ra, rb;
    logic [3:0][63:0] id_rows, rrows;
    bit               rsat;
    int               rk;

    id_beats = '0;
    id_rows  = '0;
    for (int k = 0; k < N; k++) id_beats[k] = 32'(1) << (8 * k);
    for (int r = 0; r < N; r++) id_rows[r] = 64'(1) << (16 * r);

    for (int v = 0; v < 5; v++) begin
      vecs[v].a_beats  = '0;
      vecs[v].b_beats  = '0;
      vecs[v].exp_rows = '0;
      vecs[v].exp_sat  = 1'b0;
      vecs[v].bubbles  = 0;
      vecs[v].stall    = 0;
      vecs[v].junk     = 1'b0;
    end
    vecs[0].name = "identity_x_B";
    vecs[0].k    = 4;
    vecs[0].a_beats = id_beats;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) vecs[0].b_beats[k][j*8 +: 8] = 8'(k * 4 + j);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) vecs[0].exp_rows[r][j*16 +: 16] = 16'(r * 4 + j);

    vecs[1].name    = "ones_bubbles";
    vecs[1].k       = 4;
    vecs[1].bubbles = 1;
    for (int k = 0; k < 4; k++) begin
      vecs[1].a_beats[k] = 32'h01010101;
      vecs[1].b_beats[k] = 32'h01010101;
    end
    for (int r = 0; r < 4; r++) vecs[1].exp_rows[r] = 64'h0004000400040004;

    vecs[2].name       = "k1_outer";
    vecs[2].k          = 1;
    vecs[2].a_beats[0] = 32'h04030201;
    vecs[2].b_beats[0] = 32'h08070605;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) vecs[2].exp_rows[r][j*16 +: 16] = 16'((r + 1) * (j + 5));

    vecs[3]       = vecs[2];
    vecs[3].name  = "k1_stall_junk";
    vecs[3].stall = 5;
    vecs[3].junk  = 1'b1;

    vecs[4].name = "overflow_127";
    vecs[4].k    = 3;
    for (int k = 0; k < 3; k++) begin
      vecs[4].a_beats[k] = 32'h7f7f7f7f;
      vecs[4].b_beats[k] = 32'h7f7f7f7f;
    end
`ifdef SA_SATURATE_EN
    for (int r = 0; r < 4; r++) vecs[4].exp_rows[r] = 64'h7fff7fff7fff7fff;
    vecs[4].exp_sat = 1'b1;
`else
    // 3*127*127 = 48387, which wraps to -17149 in 16 bits.
    for (int r = 0; r < 4; r++) vecs[4].exp_rows[r] = 64'hbd03bd03bd03bd03;
`endif

    #2;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_last", 64'(out_last), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset out_row", out_row, 64'd0);
    step();
    step();
    rstn = 1'b1;
    step();

    for (int v = 0; v < 5; v++)
      run_job(vecs[v].name, vecs[v].a_beats, vecs[v].b_beats, vecs[v].k, vecs[v].bubbles,
              vecs[v].stall, vecs[v].junk, vecs[v].exp_rows, vecs[v].exp_sat);

    // Abort while flushing, then a clean identity product must carry no residue.
    ra = '0;
    rb = '0;
    for (int k = 0; k < 3; k++) begin
      ra[k] = $urandom();
      rb[k] = $urandom();
    end
    feed("abort_job", ra, rb, 3, 0);
    repeat (3) step();
    check("flush busy/in_ready", {62'd0, busy, in_ready}, 64'b10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("after abort", {61'd0, busy, in_ready, out_valid}, 64'b010);
    run_job("I_after_abort", id_beats, id_beats, 4, 0, 0, 1'b0, id_rows, 1'b0);

    // Reset pulsed in the middle of feeding.
    in_valid = 1'b1;
    in_a     = 32'h11223344;
    in_b     = 32'h55667788;
    in_last  = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    check("mid-feed busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    check("in-reset flags", {60'd0, in_ready, out_valid, out_last, busy}, 64'b1000);
    check("in-reset out_row", out_row, 64'd0);
    step();
    step();
    rstn = 1'b1;
    step();
    run_job("I_after_reset", id_beats, id_beats, 4, 0, 0, 1'b0, id_rows, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rk = $urandom_range(1, 8);
      ra = '0;
      rb = '0;
      for (int k = 0; k < rk; k++) begin
        ra[k] = $urandom();
        rb[k] = $urandom();
        if (t % 2 == 0) begin
          ra[k] = ra[k] & 32'h0f0f0f0f;
          rb[k] = rb[k] | 32'hf0f0f0f0;
        end
      end
      model(ra, rb, rk, rrows, rsat);
      run_job($sformatf("rand%0d", t), ra, rb, rk, $urandom_range(0, 2), $urandom_range(0, 2),
              1'(t % 2), rrows, rsat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
